// File: rtl/sr_trace_if.sv
// Bus between the schoolRISCV core side and the retirement-trace monitor:
// the retirement stream, run-control clear, and the registered readout port.
interface sr_trace_if #(
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    // valid is a plain clock enable with no ready: the monitor accepts every
    // valid cycle, and simply drops it when it is not in RUN.
    logic          clear;
    logic          valid;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          rf_we;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;
    logic [AW-1:0] rd_idx;

    logic [31:0]   rd_pc;
    logic [31:0]   rd_instr;
    logic [31:0]   rd_wd;
    logic [4:0]    rd_wa;
    logic          rd_we;
    logic          rd_valid;
    logic [AW:0]   count;
    logic [31:0]   cycle;
    logic          overflow;
    logic          timeout;
    logic          halted;

    modport master (
        output clear, valid, pc, instr, rf_we, rf_wa, rf_wd, rd_idx,
        input  rd_pc, rd_instr, rd_wd, rd_wa, rd_we, rd_valid,
        input  count, cycle, overflow, timeout, halted
    );

    modport slave (
        input  clear, valid, pc, instr, rf_we, rf_wa, rf_wd, rd_idx,
        output rd_pc, rd_instr, rd_wd, rd_wa, rd_we, rd_valid,
        output count, cycle, overflow, timeout, halted
    );
endinterface

// File: rtl/sr_trace_monitor.sv
// Retirement-trace circular buffer plus run-control (halt / timeout) monitor
// for schoolRISCV; DEPTH must match the DEPTH of the connected sr_trace_if.
module sr_trace_monitor #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 120,
    parameter int HALT_REPEAT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_trace_if.slave   bus,
    output logic [1:0]  dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]  FULL    = (AW+1)'(DEPTH);
    localparam logic [31:0]  TO_LIM  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0]  REP_CAP = (HALT_REPEAT == 0) ? 32'hFFFF_FFFF : 32'(HALT_REPEAT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   rep_q, rep_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic          capture;
    logic          at_limit;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_wd    [DEPTH];
    logic [4:0]    mem_wa    [DEPTH];
    logic          mem_we    [DEPTH];

    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_pc_q, rd_instr_q, rd_wd_q;
    logic [4:0]    rd_wa_q;
    logic          rd_we_q, rd_valid_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        cycle_d    = cycle_q;
        overflow_d = overflow_q;
        rep_d      = rep_q;
        last_pc_d  = last_pc_q;
        capture    = 1'b0;
        at_limit   = (TIMEOUT_CYCLES != 0) && (cycle_q == TO_LIM);

        if (bus.clear) begin
            state_d    = ST_RUN;
            wr_ptr_d   = '0;
            count_d    = '0;
            cycle_d    = '0;
            overflow_d = 1'b0;
            rep_d      = '0;
            last_pc_d  = '0;
        end else if (state_q == ST_RUN && bus.valid) begin
            if (at_limit) begin
                state_d = ST_TIMEOUT;
            end else begin
                capture  = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (cycle_q != 32'hFFFF_FFFF) cycle_d = cycle_q + 32'd1;
                if (count_q == FULL) overflow_d = 1'b1;
                else                 count_d    = count_q + (AW+1)'(1);
                // rep_q == 0 marks "no PC captured yet", so the first capture never matches
                if (rep_q != 32'd0 && bus.pc == last_pc_q) begin
                    if (rep_q != REP_CAP) rep_d = rep_q + 32'd1;
                end else begin
                    rep_d = 32'd1;
                end
                last_pc_d = bus.pc;
                if (HALT_REPEAT != 0 && rep_d == REP_CAP) state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            rep_q      <= '0;
            last_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            rep_q      <= rep_d;
            last_pc_q  <= last_pc_d;
        end
    end

    // Trace storage is deliberately not reset; rd_valid guards stale entries.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_pc[wr_ptr_q]    <= bus.pc;
            mem_instr[wr_ptr_q] <= bus.instr;
            mem_wd[wr_ptr_q]    <= bus.rf_wd;
            mem_wa[wr_ptr_q]    <= bus.rf_wa;
            mem_we[wr_ptr_q]    <= bus.rf_we;
        end
    end

    // Newest entry sits just below wr_ptr; the read uses pre-capture contents.
    assign rd_addr = wr_ptr_q - AW'(1) - bus.rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pc_q    <= '0;
            rd_instr_q <= '0;
            rd_wd_q    <= '0;
            rd_wa_q    <= '0;
            rd_we_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_pc_q    <= mem_pc[rd_addr];
            rd_instr_q <= mem_instr[rd_addr];
            rd_wd_q    <= mem_wd[rd_addr];
            rd_wa_q    <= mem_wa[rd_addr];
            rd_we_q    <= mem_we[rd_addr];
            rd_valid_q <= bus.clear ? 1'b0 : ({1'b0, bus.rd_idx} < count_q);
        end
    end

    assign bus.rd_pc    = rd_pc_q;
    assign bus.rd_instr = rd_instr_q;
    assign bus.rd_wd    = rd_wd_q;
    assign bus.rd_wa    = rd_wa_q;
    assign bus.rd_we    = rd_we_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.cycle    = cycle_q;
    assign bus.overflow = overflow_q;
    assign bus.timeout  = (state_q == ST_TIMEOUT);
    assign bus.halted   = (state_q == ST_HALTED);
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_sr_trace_monitor.sv
// Directed bench for sr_trace_monitor: instance a uses default parameters,
// instance b uses TIMEOUT_CYCLES=10 for the timeout scenario.
module tb_sr_trace_monitor;
    logic clk;
    logic rst_n;
    logic [1:0] st_a, st_b;
    int checks;
    int failures;

    sr_trace_if #(.DEPTH(16)) ia ();
    sr_trace_if #(.DEPTH(16)) ib ();

    sr_trace_monitor #(.DEPTH(16), .TIMEOUT_CYCLES(120), .HALT_REPEAT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave), .dbg_state_o(st_a));
    sr_trace_monitor #(.DEPTH(16), .TIMEOUT_CYCLES(10), .HALT_REPEAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib.slave), .dbg_state_o(st_b));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks: inputs change #1 after the rising edge, outputs checked there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap_a(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        ia.valid = 1'b1; ia.pc = pc; ia.instr = 32'h1300_0000 ^ pc;
        ia.rf_we = we; ia.rf_wa = wa; ia.rf_wd = wd;
        step();
        ia.valid = 1'b0;
    endtask

    task automatic cap_b(input logic [31:0] pc);
        ib.valid = 1'b1; ib.pc = pc; ib.instr = 32'h0000_0013;
        ib.rf_we = 1'b0; ib.rf_wa = 5'd0; ib.rf_wd = 32'd0;
        step();
        ib.valid = 1'b0;
    endtask

    task automatic read_a(input logic [3:0] idx);
        ia.rd_idx = idx;
        step();
    endtask

    task automatic clear_a();
        ia.clear = 1'b1;
        step();
        ia.clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ia.clear = 0; ia.valid = 0; ia.pc = 0; ia.instr = 0; ia.rf_we = 0; ia.rf_wa = 0; ia.rf_wd = 0; ia.rd_idx = 0;
        ib.clear = 0; ib.valid = 0; ib.pc = 0; ib.instr = 0; ib.rf_we = 0; ib.rf_wa = 0; ib.rf_wd = 0; ib.rd_idx = 0;
        #12;
        checks++; if (ia.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ia.count); end
        checks++; if (ia.cycle !== 32'd0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", ia.cycle); end
        checks++; if ({ia.overflow, ia.timeout, ia.halted, ia.rd_valid} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {ia.overflow, ia.timeout, ia.halted, ia.rd_valid}); end
        checks++; if ({ia.rd_pc, ia.rd_wd, ia.rd_we} !== 65'd0) begin failures++; $display("FAIL reset_rd_data got=%0h/%0h/%0b exp=0", ia.rd_pc, ia.rd_wd, ia.rd_we); end
        checks++; if (st_a !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st_a); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) cap_a(32'(i * 4), 1'b0, 5'd0, 32'd0);
        checks++; if (ia.count !== 5'd5) begin failures++; $display("FAIL basic_count got=%0d exp=5", ia.count); end
        checks++; if (ia.cycle !== 32'd5) begin failures++; $display("FAIL basic_cycle got=%0d exp=5", ia.cycle); end
        read_a(4'd0);
        checks++; if (ia.rd_pc !== 32'd16 || ia.rd_valid !== 1'b1) begin failures++; $display("FAIL basic_rd0 got=%0d/%0b exp=16/1", ia.rd_pc, ia.rd_valid); end
        checks++; if (ia.rd_instr !== 32'h1300_0010) begin failures++; $display("FAIL basic_rd0_instr got=%0h exp=13000010", ia.rd_instr); end
        read_a(4'd4);
        checks++; if (ia.rd_pc !== 32'd0 || ia.rd_valid !== 1'b1) begin failures++; $display("FAIL basic_rd4 got=%0d/%0b exp=0/1", ia.rd_pc, ia.rd_valid); end
        read_a(4'd5);
        checks++; if (ia.rd_valid !== 1'b0) begin failures++; $display("FAIL basic_rd5_valid got=%0b exp=0", ia.rd_valid); end
        checks++; if (ia.overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%0b exp=0", ia.overflow); end
    endtask

    task automatic test_overflow();
        clear_a();
        checks++; if (ia.count !== 5'd0 || ia.cycle !== 32'd0) begin failures++; $display("FAIL clear_counters got=%0d/%0d exp=0/0", ia.count, ia.cycle); end
        for (int i = 0; i < 20; i++) cap_a(32'(i * 4), 1'b0, 5'd0, 32'd0);
        checks++; if (ia.count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", ia.count); end
        checks++; if (ia.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", ia.overflow); end
        checks++; if (ia.cycle !== 32'd20) begin failures++; $display("FAIL ovf_cycle got=%0d exp=20", ia.cycle); end
        read_a(4'd15);
        checks++; if (ia.rd_pc !== 32'd16 || ia.rd_valid !== 1'b1) begin failures++; $display("FAIL ovf_rd15 got=%0d/%0b exp=16/1", ia.rd_pc, ia.rd_valid); end
    endtask

    task automatic test_back_to_back();
        // newest is PC 76; each cycle both checks the previous index and issues the next
        logic [31:0] exp_pc;
        ia.rd_idx = 4'd0;
        step();
        for (int i = 1; i <= 4; i++) begin
            exp_pc = 32'(76 - (i - 1) * 4);
            checks++; if (ia.rd_pc !== exp_pc) begin failures++; $display("FAIL b2b_rd%0d got=%0d exp=%0d", i - 1, ia.rd_pc, exp_pc); end
            ia.rd_idx = 4'(i);
            step();
        end
    endtask

    task automatic test_halt();
        clear_a();
        cap_a(32'd0, 1'b0, 5'd0, 32'd0);
        cap_a(32'd4, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) cap_a(32'd8, 1'b0, 5'd0, 32'd0);
        checks++; if (ia.halted !== 1'b0) begin failures++; $display("FAIL halt_early got=%0b exp=0", ia.halted); end
        cap_a(32'd8, 1'b0, 5'd0, 32'd0);
        checks++; if (ia.halted !== 1'b1 || ia.timeout !== 1'b0 || st_a !== 2'd1) begin failures++; $display("FAIL halt_flag got=%0b/%0b/%0d exp=1/0/1", ia.halted, ia.timeout, st_a); end
        checks++; if (ia.cycle !== 32'd6 || ia.count !== 5'd6) begin failures++; $display("FAIL halt_counters got=%0d/%0d exp=6/6", ia.cycle, ia.count); end
        for (int i = 0; i < 3; i++) cap_a(32'd100 + 32'(i), 1'b0, 5'd0, 32'd0);
        checks++; if (ia.cycle !== 32'd6 || ia.count !== 5'd6) begin failures++; $display("FAIL halt_frozen got=%0d/%0d exp=6/6", ia.cycle, ia.count); end
        read_a(4'd0);
        checks++; if (ia.rd_pc !== 32'd8 || ia.rd_valid !== 1'b1) begin failures++; $display("FAIL halt_readout got=%0d/%0b exp=8/1", ia.rd_pc, ia.rd_valid); end
    endtask

    task automatic test_clear_halted();
        clear_a();
        checks++; if (ia.count !== 5'd0 || ia.halted !== 1'b0 || st_a !== 2'd0) begin failures++; $display("FAIL clrh_state got=%0d/%0b/%0d exp=0/0/0", ia.count, ia.halted, st_a); end
        checks++; if (ia.rd_valid !== 1'b0) begin failures++; $display("FAIL clrh_rd_valid got=%0b exp=0", ia.rd_valid); end
        cap_a(32'd8, 1'b0, 5'd0, 32'd0);
        checks++; if (ia.count !== 5'd1) begin failures++; $display("FAIL clrh_first got=%0d exp=1", ia.count); end
        cap_a(32'd8, 1'b0, 5'd0, 32'd0);
        cap_a(32'd8, 1'b0, 5'd0, 32'd0);
        checks++; if (ia.halted !== 1'b0) begin failures++; $display("FAIL clrh_rep_restart got=%0b exp=0", ia.halted); end
        cap_a(32'd8, 1'b0, 5'd0, 32'd0);
        checks++; if (ia.halted !== 1'b1) begin failures++; $display("FAIL clrh_rehalt got=%0b exp=1", ia.halted); end
        // clear wins over a simultaneous valid
        ia.clear = 1'b1;
        cap_a(32'd200, 1'b0, 5'd0, 32'd0);
        ia.clear = 1'b0;
        checks++; if (ia.count !== 5'd0 || ia.cycle !== 32'd0) begin failures++; $display("FAIL clear_prio got=%0d/%0d exp=0/0", ia.count, ia.cycle); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 10; i++) cap_b(32'(i * 4));
        checks++; if (ib.cycle !== 32'd10 || ib.timeout !== 1'b0) begin failures++; $display("FAIL to_at_limit got=%0d/%0b exp=10/0", ib.cycle, ib.timeout); end
        cap_b(32'd40);
        checks++; if (ib.timeout !== 1'b1 || ib.halted !== 1'b0 || st_b !== 2'd2) begin failures++; $display("FAIL to_flag got=%0b/%0b/%0d exp=1/0/2", ib.timeout, ib.halted, st_b); end
        checks++; if (ib.cycle !== 32'd10 || ib.count !== 5'd10) begin failures++; $display("FAIL to_counters got=%0d/%0d exp=10/10", ib.cycle, ib.count); end
        cap_b(32'd44);
        ib.rd_idx = 4'd0;
        step();
        checks++; if (ib.rd_pc !== 32'd36 || ib.cycle !== 32'd10) begin failures++; $display("FAIL to_not_stored got=%0d/%0d exp=36/10", ib.rd_pc, ib.cycle); end
    endtask

    task automatic test_async_reset();
        clear_a();
        cap_a(32'd0, 1'b1, 5'd3, 32'd7);
        cap_a(32'd4, 1'b1, 5'd4, 32'd9);
        ia.rd_idx = 4'd0;
        step();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (ia.count !== 5'd0 || ia.cycle !== 32'd0) begin failures++; $display("FAIL arst_counters got=%0d/%0d exp=0/0", ia.count, ia.cycle); end
        checks++; if (ia.rd_valid !== 1'b0 || ia.rd_pc !== 32'd0 || ia.rd_wd !== 32'd0) begin failures++; $display("FAIL arst_rd got=%0b/%0h/%0h exp=0/0/0", ia.rd_valid, ia.rd_pc, ia.rd_wd); end
        #2 rst_n = 1'b1;
        step();
        cap_a(32'h40, 1'b1, 5'd10, 32'h2A);
        read_a(4'd0);
        checks++; if (ia.rd_we !== 1'b1 || ia.rd_wa !== 5'd10 || ia.rd_wd !== 32'h2A) begin failures++; $display("FAIL arst_rf got=%0b/%0d/%0h exp=1/10/2a", ia.rd_we, ia.rd_wa, ia.rd_wd); end
        checks++; if (ia.rd_pc !== 32'h40 || ia.count !== 5'd1) begin failures++; $display("FAIL arst_entry got=%0h/%0d exp=40/1", ia.rd_pc, ia.count); end
        // x0 write with rf_we=0 is still stored verbatim
        cap_a(32'h44, 1'b0, 5'd0, 32'h55);
        read_a(4'd0);
        checks++; if (ia.rd_we !== 1'b0 || ia.rd_wa !== 5'd0 || ia.rd_wd !== 32'h55) begin failures++; $display("FAIL verbatim_rf got=%0b/%0d/%0h exp=0/0/55", ia.rd_we, ia.rd_wa, ia.rd_wd); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_halt();
        test_clear_halted();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
